// File: rtl/pocket_array_renderer_if.sv
// Pixel/animation bus between the pocket renderer and its surroundings.
// The master drives pixel coordinates and event strobes; the slave returns the colour.
interface pocket_array_renderer_if #(
  parameter int NUM_HOLES = 6
);
  logic signed [10:0]    pixelX;
  logic signed [10:0]    pixelY;
  logic                  startOfFrame;
  logic [NUM_HOLES-1:0]  sinkPulse;
  logic                  drawingRequestHole;
  logic [7:0]            RGBoutHole;
  logic [2:0]            holeIndex;
  logic [NUM_HOLES-1:0]  flashActive;

  modport master (
    output pixelX, pixelY, startOfFrame, sinkPulse,
    input  drawingRequestHole, RGBoutHole, holeIndex, flashActive
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, sinkPulse,
    output drawingRequestHole, RGBoutHole, holeIndex, flashActive
  );
endinterface

// File: rtl/pocket_array_renderer.sv
// Procedural renderer for NUM_HOLES circular pockets with a per-pocket
// "ball sunk" blink animation. Two registered stages: bounding-box select,
// then circle test and colour pick. Lowest pocket index wins on overlap.
module pocket_array_renderer #(
  parameter int                      NUM_HOLES            = 6,
  parameter logic [11*NUM_HOLES-1:0] HOLE_CX              = {11'd48, 11'd320, 11'd592, 11'd48, 11'd320, 11'd592},
  parameter logic [11*NUM_HOLES-1:0] HOLE_CY              = {11'd48, 11'd48, 11'd48, 11'd432, 11'd432, 11'd432},
  parameter int                      RADIUS               = 14,
  parameter int                      RIM_WIDTH            = 2,
  parameter logic [7:0]              CORE_COLOR           = 8'h00,
  parameter logic [7:0]              RIM_COLOR            = 8'h49,
  parameter logic [7:0]              FLASH_COLOR          = 8'hFC,
  parameter int                      FLASH_FRAMES         = 60,
  parameter int                      BLINK_FRAMES         = 8,
  parameter logic [7:0]              TRANSPARENT_ENCODING = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst,
  pocket_array_renderer_if.slave bus
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic signed [12:0] R_POS   = 13'(RADIUS);
  localparam logic signed [12:0] R_NEG   = -R_POS;
  localparam logic [23:0]        R2_OUT  = 24'(RADIUS * RADIUS);
  localparam logic [23:0]        R2_IN   = 24'((RADIUS - RIM_WIDTH) * (RADIUS - RIM_WIDTH));
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [BLK_W-1:0]   BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } flash_state_t;

  // Animation state per pocket
  flash_state_t                    state_r [NUM_HOLES];
  flash_state_t                    state_s [NUM_HOLES];
  logic [NUM_HOLES-1:0][CNT_W-1:0] cnt_r, cnt_s;
  logic [NUM_HOLES-1:0][BLK_W-1:0] blink_r, blink_s;
  logic [NUM_HOLES-1:0]            phase_r, phase_s;
  logic [7:0]                      flash_on_s;
  logic [NUM_HOLES-1:0]            flash_act_s;

  // Stage 1 (box select) and stage 2 (colour) signals
  logic signed [12:0] dx_s [NUM_HOLES];
  logic signed [12:0] dy_s [NUM_HOLES];
  logic               hit_s;
  logic [2:0]         hit_idx_s;
  logic signed [11:0] hit_dx_s, hit_dy_s;
  logic               s1_valid_r;
  logic [2:0]         s1_idx_r;
  logic signed [11:0] s1_dx_r, s1_dy_r;
  logic signed [23:0] dx_w_s, dy_w_s, sqx_s, sqy_s;
  logic [23:0]        d2_s;
  logic [7:0]         rgb_s, rgb_r;
  logic [2:0]         idx_s, idx_r;

  // Offsets from every pocket centre, widened so far-off pixels cannot wrap into a hit
  always_comb begin
    for (int i = 0; i < NUM_HOLES; i++) begin
      dx_s[i] = $signed({{2{bus.pixelX[10]}}, bus.pixelX}) - $signed({2'b00, HOLE_CX[(NUM_HOLES-1-i)*11 +: 11]});
      dy_s[i] = $signed({{2{bus.pixelY[10]}}, bus.pixelY}) - $signed({2'b00, HOLE_CY[(NUM_HOLES-1-i)*11 +: 11]});
    end
  end

  // Priority select: scanning downward lets the lowest-index hit overwrite the rest
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = 3'd0;
    hit_dx_s  = 12'sd0;
    hit_dy_s  = 12'sd0;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      if ((dx_s[i] >= R_NEG) && (dx_s[i] <= R_POS) && (dy_s[i] >= R_NEG) && (dy_s[i] <= R_POS)) begin
        hit_s     = 1'b1;
        hit_idx_s = 3'(i);
        hit_dx_s  = dx_s[i][11:0];
        hit_dy_s  = dy_s[i][11:0];
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Stage 1 register: selected pocket and its offsets
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_idx_r   <= 3'd0;
      s1_dx_r    <= 12'sd0;
      s1_dy_r    <= 12'sd0;
    end else begin
      s1_valid_r <= hit_s;
      s1_idx_r   <= hit_idx_s;
      s1_dx_r    <= hit_dx_s;
      s1_dy_r    <= hit_dy_s;
    end
  end

  assign dx_w_s = 24'(s1_dx_r);
  assign dy_w_s = 24'(s1_dy_r);
  assign sqx_s  = dx_w_s * dx_w_s;
  assign sqy_s  = dy_w_s * dy_w_s;
  assign d2_s   = $unsigned(sqx_s) + $unsigned(sqy_s);

  // Blink-on flags padded to the 3-bit index range so stage 2 never indexes out of bounds
  always_comb begin
    flash_on_s  = 8'h00;
    flash_act_s = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      flash_on_s[i]  = (state_r[i] == ST_FLASH) && phase_r[i];
      flash_act_s[i] = (state_r[i] == ST_FLASH);
    end
  end

  // Stage 2 colour: core / rim / transparent, only the core can flash
  always_comb begin
    rgb_s = TRANSPARENT_ENCODING;
    idx_s = 3'd0;
    if (s1_valid_r) begin
      if (d2_s < R2_IN) begin
        rgb_s = flash_on_s[s1_idx_r] ? FLASH_COLOR : CORE_COLOR;
        idx_s = s1_idx_r;
      end else if (d2_s < R2_OUT) begin
        rgb_s = RIM_COLOR;
        idx_s = s1_idx_r;
      end else begin
        rgb_s = TRANSPARENT_ENCODING;
        idx_s = 3'd0;
      end
    end else begin
      rgb_s = TRANSPARENT_ENCODING;
      idx_s = 3'd0;
    end
  end

  // Stage 2 register: output colour and pocket index
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= TRANSPARENT_ENCODING;
      idx_r <= 3'd0;
    end else begin
      rgb_r <= rgb_s;
      idx_r <= idx_s;
    end
  end

  // Next-state for each pocket's flash animation; a sink always wins over the frame strobe
  always_comb begin
    for (int i = 0; i < NUM_HOLES; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      blink_s[i] = blink_r[i];
      phase_s[i] = phase_r[i];
      case (state_r[i])
        ST_IDLE: begin
          if (bus.sinkPulse[i]) begin
            state_s[i] = ST_FLASH;
            cnt_s[i]   = '0;
            blink_s[i] = '0;
            phase_s[i] = 1'b1;
          end else begin
            state_s[i] = ST_IDLE;
          end
        end
        ST_FLASH: begin
          if (bus.sinkPulse[i]) begin
            cnt_s[i]   = '0;
            blink_s[i] = '0;
            phase_s[i] = 1'b1;
          end else if (bus.startOfFrame) begin
            if (cnt_r[i] == CNT_LAST) begin
              state_s[i] = ST_IDLE;
              cnt_s[i]   = '0;
              blink_s[i] = '0;
              phase_s[i] = 1'b0;
            end else begin
              cnt_s[i] = cnt_r[i] + CNT_W'(1);
              if (blink_r[i] == BLK_LAST) begin
                blink_s[i] = '0;
                phase_s[i] = ~phase_r[i];
              end else begin
                blink_s[i] = blink_r[i] + BLK_W'(1);
              end
            end
          end else begin
            state_s[i] = ST_FLASH;
          end
        end
        default: begin
          state_s[i] = ST_IDLE;
          cnt_s[i]   = '0;
          blink_s[i] = '0;
          phase_s[i] = 1'b0;
        end
      endcase
    end
  end

  // Animation state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_HOLES; i++) begin
        state_r[i] <= ST_IDLE;
      end
      cnt_r   <= '0;
      blink_r <= '0;
      phase_r <= '0;
    end else begin
      for (int i = 0; i < NUM_HOLES; i++) begin
        state_r[i] <= state_s[i];
      end
      cnt_r   <= cnt_s;
      blink_r <= blink_s;
      phase_r <= phase_s;
    end
  end

  assign bus.RGBoutHole         = rgb_r;
  assign bus.holeIndex          = idx_r;
  assign bus.drawingRequestHole = (rgb_r != TRANSPARENT_ENCODING);
  assign bus.flashActive        = flash_act_s;

endmodule
